// File: rtl/qnet_dbg_trace.sv
// qnet_dbg_trace
//   Debug trace buffer for the command-state history. When armed, every change
//   of the 6-bit state code (debug_dt_i[29:24]) is stored with a timestamp in a
//   circular buffer. The first error code (63) starts a post-trigger window of
//   POST_N further entries, after which the buffer freezes for readout.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | after reset; nothing captured, reads allowed
//   CAPTURE | recording code changes, waiting for the error code
//   POST    | recording POST_N entries after the error entry
//   FROZEN  | capture stopped, buffer held for readout
//
// Ports
//   st_clk_i     clock
//   st_rst_i     synchronous reset, active-high
//   debug_dt_i   packed command-state history, [29:24] = newest code
//   arm_i        pulse: clear buffer/timestamp and start capture
//   rd_req_i     pulse: pop the oldest entry (IDLE/FROZEN only)
//   rd_ack_o     single-cycle read acknowledge
//   rd_data_o    {timestamp, code} of the popped entry
//   rd_empty_o   acknowledged read found the buffer empty
//   count_o      number of stored entries
//   capturing_o  state is CAPTURE or POST
//   frozen_o     state is FROZEN
//   overflow_o   an entry was overwritten since the last arm
module qnet_dbg_trace #(
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int POST_N = 4
) (
  input  logic                       st_clk_i,
  input  logic                       st_rst_i,
  input  logic [31:0]                debug_dt_i,
  input  logic                       arm_i,
  input  logic                       rd_req_i,
  output logic                       rd_ack_o,
  output logic [TS_W+5:0]            rd_data_o,
  output logic                       rd_empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       capturing_o,
  output logic                       frozen_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = TS_W + 6;
  localparam logic [5:0]    CODE_ERR  = 6'd63;
  localparam logic [5:0]    CODE_INIT = 6'd62;
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [AW-1:0] POST_LD   = AW'(POST_N);
  localparam bit            HAS_POST  = (POST_N > 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_POST    = 2'd2,
    S_FROZEN  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TS_W-1:0] ts_q;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic [5:0]      prev_code_q;
  logic [AW-1:0]   post_cnt_q;
  logic            overflow_q;
  logic            rd_ack_q;
  logic [DW-1:0]   rd_data_q;
  logic            rd_empty_q;
  logic            capturing_q;
  logic            frozen_q;
  logic [DW-1:0]   mem [DEPTH];

  logic [5:0] code;
  logic       active;
  logic       wr_en;
  logic       rd_go;
  logic       err_entry;

  always_comb begin
    code      = debug_dt_i[29:24];
    active    = (state_q == S_CAPTURE) || (state_q == S_POST);
    // arm_i suppresses both writes and reads in its own cycle
    wr_en     = active && !arm_i && (code != prev_code_q);
    rd_go     = rd_req_i && !arm_i && !rd_ack_q &&
                ((state_q == S_IDLE) || (state_q == S_FROZEN));
    err_entry = wr_en && (state_q == S_CAPTURE) && (code == CODE_ERR);
  end

  always_comb begin
    state_d = state_q;
    if (arm_i) begin
      state_d = S_CAPTURE;
    end else begin
      case (state_q)
        S_CAPTURE: if (err_entry) state_d = HAS_POST ? S_POST : S_FROZEN;
        // the write that takes the counter from 1 to 0 ends the window
        S_POST:    if (wr_en && (post_cnt_q == AW'(1))) state_d = S_FROZEN;
        default:   state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge st_clk_i) begin
    if (st_rst_i) begin
      state_q     <= S_IDLE;
      ts_q        <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      prev_code_q <= CODE_INIT;
      post_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_data_q   <= '0;
      rd_empty_q  <= 1'b0;
      capturing_q <= 1'b0;
      frozen_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      capturing_q <= (state_d == S_CAPTURE) || (state_d == S_POST);
      frozen_q    <= (state_d == S_FROZEN);
      rd_ack_q    <= rd_go;
      if (arm_i) begin
        ts_q        <= '0;
        wptr_q      <= '0;
        rptr_q      <= '0;
        count_q     <= '0;
        prev_code_q <= CODE_INIT;
        post_cnt_q  <= '0;
        overflow_q  <= 1'b0;
      end else begin
        if (state_q != S_IDLE) ts_q <= ts_q + 1'b1;
        if (active) prev_code_q <= code;
        if (wr_en) begin
          wptr_q <= wptr_q + 1'b1;
          if (count_q == CNT_FULL) begin
            // full: the new entry replaces the oldest one
            rptr_q     <= rptr_q + 1'b1;
            overflow_q <= 1'b1;
          end else begin
            count_q <= count_q + 1'b1;
          end
          if (err_entry) post_cnt_q <= POST_LD;
          else if (state_q == S_POST) post_cnt_q <= post_cnt_q - 1'b1;
        end
        // reads and writes are never live in the same state
        if (rd_go) begin
          if (count_q != '0) begin
            rd_data_q  <= mem[rptr_q];
            rd_empty_q <= 1'b0;
            rptr_q     <= rptr_q + 1'b1;
            count_q    <= count_q - 1'b1;
          end else begin
            rd_data_q  <= '0;
            rd_empty_q <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge st_clk_i) begin
    if (!st_rst_i && wr_en) mem[wptr_q] <= {ts_q, code};
  end

  assign rd_ack_o    = rd_ack_q;
  assign rd_data_o   = rd_data_q;
  assign rd_empty_o  = rd_empty_q;
  assign count_o     = count_q;
  assign capturing_o = capturing_q;
  assign frozen_o    = frozen_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_qnet_dbg_trace.sv
module tb_qnet_dbg_trace;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dt;
  logic        arm;
  logic        rd_req;
  logic        rd_ack;
  logic [21:0] rd_data;
  logic        rd_empty;
  logic [4:0]  count;
  logic        capturing;
  logic        frozen;
  logic        overflow;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qnet_dbg_trace #(.DEPTH(16), .TS_W(16), .POST_N(4)) dut (
    .st_clk_i    (clk),
    .st_rst_i    (rst),
    .debug_dt_i  (dt),
    .arm_i       (arm),
    .rd_req_i    (rd_req),
    .rd_ack_o    (rd_ack),
    .rd_data_o   (rd_data),
    .rd_empty_o  (rd_empty),
    .count_o     (count),
    .capturing_o (capturing),
    .frozen_o    (frozen),
    .overflow_o  (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle so outputs reflect that edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_code(input int c);
    dt = {2'b11, 6'(c), 24'hA5C3E1};
  endtask

  task automatic feed(input int c);
    set_code(c);
    step();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic do_read(input string tag, input int exp_data, input bit exp_empty);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk({tag, "_ack"}, rd_ack, 1);
    chk({tag, "_data"}, rd_data, exp_data);
    chk({tag, "_empty"}, rd_empty, exp_empty);
    step();
    chk({tag, "_ackdrop"}, rd_ack, 0);
    chk({tag, "_hold"}, rd_data, exp_data);
  endtask

  initial begin
    int exp_code, exp_ts;
    rst = 1'b1; arm = 1'b0; rd_req = 1'b0; dt = '0;
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_capturing", capturing, 0);
    chk("rst_frozen", frozen, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ack", rd_ack, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_empty", rd_empty, 0);
    rst = 1'b0;
    step();

    // codes 1,1,2,2,5 -> three entries
    do_arm();
    chk("arm_capturing", capturing, 1);
    feed(1); feed(1); feed(2); feed(2); feed(5);
    chk("s1_count", count, 3);
    // reads are ignored while capturing
    rd_req = 1'b1; step(); rd_req = 1'b0;
    chk("s1_rd_in_capture", rd_ack, 0);
    step();
    chk("s1_rd_in_capture2", rd_ack, 0);
    chk("s1_count_kept", count, 3);
    // arm together with a code change: nothing written
    set_code(7);
    do_arm();
    chk("armchg_count", count, 0);
    chk("armchg_capturing", capturing, 1);
    step();
    chk("armchg_next_write", count, 1);

    // POST window: 1,63,2,3,4,5,6 ; entry data = ts*64 + code
    do_arm();
    feed(1); feed(63); feed(2); feed(3); feed(4);
    chk("s3_in_post_capt", capturing, 1);
    chk("s3_in_post_frz", frozen, 0);
    chk("s3_count5", count, 5);
    feed(5);
    chk("s3_frozen", frozen, 1);
    chk("s3_capt_off", capturing, 0);
    chk("s3_count6", count, 6);
    feed(6);
    chk("s3_code6_ignored", count, 6);
    // request held two cycles: second cycle is dropped while ack is high
    rd_req = 1'b1;
    step();
    chk("s3_rd0_ack", rd_ack, 1);
    chk("s3_rd0_data", rd_data, 1);
    chk("s3_rd0_count", count, 5);
    step();
    rd_req = 1'b0;
    chk("s3_rd0_dup_ack", rd_ack, 0);
    chk("s3_rd0_dup_count", count, 5);
    step();
    do_read("s3_rd1", 64 + 63, 0);
    do_read("s3_rd2", 2*64 + 2, 0);
    do_read("s3_rd3", 3*64 + 3, 0);
    chk("s3_two_left", count, 2);
    do_read("s3_rd4", 4*64 + 4, 0);
    do_read("s3_rd5", 5*64 + 5, 0);
    do_read("s3_rd_empty", 0, 1);
    chk("s3_count_zero", count, 0);

    // overflow: codes 1..20 with code k at ts k-1
    do_arm();
    for (int k = 1; k <= 20; k++) feed(k);
    chk("s2_count_full", count, 16);
    chk("s2_overflow", overflow, 1);
    chk("s2_still_capt", capturing, 1);
    // freeze via 63 + four more: buffer then holds 10..20, 63, 21..24
    feed(63);
    for (int k = 21; k <= 24; k++) feed(k);
    chk("s2_frozen", frozen, 1);
    chk("s2_count", count, 16);
    for (int i = 0; i < 14; i++) begin
      if (i < 11) begin
        exp_code = 10 + i; exp_ts = 9 + i;
      end else if (i == 11) begin
        exp_code = 63; exp_ts = 20;
      end else begin
        exp_code = 21 + (i - 12); exp_ts = exp_code;
      end
      do_read($sformatf("s2_rd%0d", i), exp_ts*64 + exp_code, 0);
    end
    chk("s2_two_left", count, 2);
    // arm together with a read: arm wins
    set_code(40);
    arm = 1'b1; rd_req = 1'b1;
    step();
    arm = 1'b0; rd_req = 1'b0;
    chk("armrd_ack", rd_ack, 0);
    chk("armrd_count", count, 0);
    chk("armrd_capturing", capturing, 1);
    chk("armrd_frozen", frozen, 0);
    chk("armrd_overflow", overflow, 0);
    step();
    chk("armrd_ack_late", rd_ack, 0);

    // reset in POST with post counter at 2, read request pending
    do_arm();
    feed(1); feed(63); feed(2); feed(3);
    chk("s6_in_post", capturing, 1);
    chk("s6_count", count, 4);
    rst = 1'b1; rd_req = 1'b1; set_code(9);
    step();
    chk("s6_rst_count", count, 0);
    chk("s6_rst_frozen", frozen, 0);
    chk("s6_rst_overflow", overflow, 0);
    chk("s6_rst_capt", capturing, 0);
    chk("s6_rst_ack", rd_ack, 0);
    rst = 1'b0; rd_req = 1'b0;
    step();
    chk("s6_no_ack_after", rd_ack, 0);
    chk("s6_idle", capturing, 0);
    feed(12);
    chk("s6_idle_no_write", count, 0);
    do_read("s6_idle_rd", 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
